waveform_to_pipe_bram: RTL

- Capture-side counterpart of the pipe-loaded waveform player.
- Records DEPTH 32-bit samples on sample_clk into an inferred dual-clock RAM after a host arm command.
- Exposes the stored record to the host as a 16-bit pipe-out stream on pipe_clk.
- Sits between a neuron/spike datapath (sample side) and the host pipe-out endpoint (pipe side).

---
 rtl/wave_capture_pkg.sv | 10 +
 rtl/waveform_to_pipe_bram_cdc_toggle_sync.sv | 19 +
 rtl/waveform_to_pipe_bram.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/wave_capture_pkg.sv
// Shared encodings and widths for the waveform capture block.
`timescale 1ns/1ps
package wave_capture_pkg;
  localparam int PIPE_W         = 16;
  localparam int SAMPLE_W       = 32;
  localparam int ADDR_W_DEFAULT = 10;

  typedef enum logic [1:0] {P_IDLE, P_BUSY, P_DONE} pipe_state_e;
  typedef enum logic [1:0] {S_IDLE, S_CAPT, S_WAIT} samp_state_e;
endpackage

// File: rtl/waveform_to_pipe_bram_cdc_toggle_sync.sv
// Two-flop toggle synchroniser; the third flop turns each toggle into a one-cycle pulse.
`timescale 1ns/1ps
module cdc_toggle_sync (
  input  logic clk,
  input  logic rst,
  input  logic tgl_in,
  output logic pulse
);
  logic [2:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[1:0], tgl_in};

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign pulse = sync_q[1] ^ sync_q[2];
endmodule

// File: rtl/waveform_to_pipe_bram.sv
// Captures 2**ADDR_W samples on sample_clk after arm and streams them out as 16-bit pipe words.
// Build option WAVE_CAPTURE_TRIG_EN adds a trig input that gates the capture start.
//   state  | meaning
//   P_IDLE | no capture requested since reset
//   P_BUSY | arm accepted, capture still running
//   P_DONE | record complete and readable
//   S_IDLE | sample side waiting for an arm edge
//   S_WAIT | armed, waiting for trig with a valid sample
//   S_CAPT | storing valid samples
`timescale 1ns/1ps
module waveform_to_pipe_bram
  import wave_capture_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic                pipe_clk,
  input  logic                reset,
  input  logic                sample_clk,
  input  logic                arm,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
`ifdef WAVE_CAPTURE_TRIG_EN
  input  logic                trig,
`endif
  output logic                busy,
  output logic                done,
  input  logic                pipe_out_read,
  output logic [PIPE_W-1:0]   pipe_out_data
);
  localparam int DEPTH = 2**ADDR_W;

  pipe_state_e         pipe_state_q, pipe_state_d;
  logic                arm_tgl_q, arm_tgl_d;
  logic [ADDR_W:0]     rd_addr_q, rd_addr_d;
  logic [SAMPLE_W-1:0] rd_word_q;
  logic                rd_half_q;
  logic                done_pulse;

  samp_state_e         samp_state_q, samp_state_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic                done_tgl_q, done_tgl_d;
  logic [1:0]          srst_q, srst_d;
  logic                srst;
  logic                arm_pulse;
  logic                wr_en;

  logic [SAMPLE_W-1:0] mem [DEPTH];

  // Pipe side: an accepted arm takes priority over a simultaneous read strobe.
  always_comb begin
    pipe_state_d = pipe_state_q;
    arm_tgl_d    = arm_tgl_q;
    rd_addr_d    = rd_addr_q + (ADDR_W+1)'(pipe_out_read);
    case (pipe_state_q)
      P_BUSY: if (done_pulse) pipe_state_d = P_DONE;
      default: begin
        if (arm) begin
          pipe_state_d = P_BUSY;
          arm_tgl_d    = ~arm_tgl_q;
          rd_addr_d    = '0;
        end
      end
    endcase
  end

  always_ff @(posedge pipe_clk) begin
    if (reset) begin
      pipe_state_q <= P_IDLE;
      arm_tgl_q    <= 1'b0;
      rd_addr_q    <= '0;
      rd_word_q    <= '0;
      rd_half_q    <= 1'b0;
    end else begin
      pipe_state_q <= pipe_state_d;
      arm_tgl_q    <= arm_tgl_d;
      rd_addr_q    <= rd_addr_d;
      rd_word_q    <= mem[rd_addr_d[ADDR_W:1]];
      rd_half_q    <= rd_addr_d[0];
    end
  end

  assign busy          = (pipe_state_q == P_BUSY);
  assign done          = (pipe_state_q == P_DONE);
  assign pipe_out_data = rd_half_q ? rd_word_q[PIPE_W +: PIPE_W] : rd_word_q[0 +: PIPE_W];

  always_comb srst_d = {srst_q[0], reset};
  always_ff @(posedge sample_clk) srst_q <= srst_d;
  assign srst = srst_q[1];

  cdc_toggle_sync u_arm_sync (
    .clk    (sample_clk),
    .rst    (srst),
    .tgl_in (arm_tgl_q),
    .pulse  (arm_pulse)
  );

  cdc_toggle_sync u_done_sync (
    .clk    (pipe_clk),
    .rst    (reset),
    .tgl_in (done_tgl_q),
    .pulse  (done_pulse)
  );

  // Capture stops at the last address; no wrap, so a record is never overwritten.
  always_comb begin
    samp_state_d = samp_state_q;
    wr_addr_d    = wr_addr_q;
    done_tgl_d   = done_tgl_q;
    wr_en        = 1'b0;
    case (samp_state_q)
      S_CAPT: begin
        if (sample_valid) begin
          wr_en     = 1'b1;
          wr_addr_d = wr_addr_q + 1'b1;
          if (wr_addr_q == '1) begin
            done_tgl_d   = ~done_tgl_q;
            samp_state_d = S_IDLE;
          end
        end
      end
`ifdef WAVE_CAPTURE_TRIG_EN
      S_WAIT: begin
        if (sample_valid && trig) begin
          wr_en        = 1'b1;
          wr_addr_d    = wr_addr_q + 1'b1;
          samp_state_d = S_CAPT;
        end
      end
`endif
      default: begin
        if (arm_pulse) begin
          wr_addr_d = '0;
`ifdef WAVE_CAPTURE_TRIG_EN
          samp_state_d = S_WAIT;
`else
          samp_state_d = S_CAPT;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge sample_clk) begin
    if (srst) begin
      samp_state_q <= S_IDLE;
      wr_addr_q    <= '0;
      done_tgl_q   <= 1'b0;
    end else begin
      samp_state_q <= samp_state_d;
      wr_addr_q    <= wr_addr_d;
      done_tgl_q   <= done_tgl_d;
    end
  end

  always_ff @(posedge sample_clk) begin
    if (wr_en) mem[wr_addr_q] <= sample_data;
  end
endmodule
